btb_update_unit: RTL

- Sits at the execute/branch-resolution end of the pipeline and produces the BTB write-side traffic: `btb_load`, `btb_write_address` and the `btb_in` entry.
- Compares each resolved control-flow instruction against the prediction carried down from fetch.
- Raises a registered mispredict redirect.
- Computes the new 2-bit saturating counter and target, and buffers updates in a small FIFO that drains one write per cycle into the BTB write port.

---
 rtl/rv32i_types.sv | 28 ++
 rtl/btb_update_fifo.sv | 56 +++++
 rtl/btb_update_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the BTB update path: the BTB entry layout, the queued
// update record, and the 2-bit saturating counter step.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry;

  typedef struct packed {
    rv32i_word pc;
    btb_entry  entry;
  } btb_update_t;

  localparam logic [1:0] BTB_CTR_WEAK_TAKEN = 2'b10;

  // Next counter value. A miss only reaches the queue when the branch was
  // taken, so a freshly allocated entry starts out weakly taken.
  function automatic logic [1:0] ctr_next(input logic hit, input logic taken,
                                          input logic [1:0] ctr);
    if (!hit) return BTB_CTR_WEAK_TAKEN;
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// Circular queue of pending BTB updates. Besides a normal push it can
// rewrite the youngest entry in place so repeated updates to one PC coalesce.
module btb_update_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              overwrite_tail,
  input  btb_update_t       wr_data,
  input  logic              pop,
  output btb_update_t       head_data,
  output rv32i_word         tail_pc,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count
);

  btb_update_t      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tail_prev;

  assign tail_prev = tail - PTR_W'(1);
  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign head_data = mem[head];
  assign tail_pc   = mem[tail_prev].pc;

  // Pointer and occupancy tracking; reset drops everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)  head <= head + PTR_W'(1);
      if (push) tail <= tail + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents of unoccupied slots are never observed.
  always_ff @(posedge clk) begin
    if (push)                mem[tail]      <= wr_data;
    else if (overwrite_tail) mem[tail_prev] <= wr_data;
  end

endmodule

// File: rtl/btb_update_unit.sv
// Branch-resolution side of the BTB: detects mispredictions against the
// fetch-time prediction, raises a registered redirect, and queues counter /
// target updates that drain one per cycle into the BTB write port.
module btb_update_unit
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           res_valid,
  output logic           res_ready,
  input  logic [31:0]    res_pc,
  input  logic           res_taken,
  input  logic [31:0]    res_target,
  input  logic           res_btb_hit,
  input  btb_entry       res_btb_entry,
  input  logic           btb_wr_grant,
  output logic           btb_load,
  output logic [31:0]    btb_write_address,
  output btb_entry       btb_in,
  output logic           mispredict,
  output logic [31:0]    redirect_pc,
  output logic [PTR_W:0] fifo_count
);

  logic        full;
  logic        empty;
  logic        pop;
  logic        acc;
  logic        pred_taken;
  logic        mis_cond;
  logic        enq;
  logic        coalesce;
  logic        push;
  btb_update_t head_data;
  btb_update_t upd;
  rv32i_word   tail_pc;

  assign btb_load   = !empty;
  assign pop        = btb_load && btb_wr_grant;
  assign res_ready  = !full || pop;
  assign acc        = res_valid && res_ready;

  assign pred_taken = res_btb_hit && res_btb_entry.ctr[1];
  assign mis_cond   = (pred_taken != res_taken) ||
                      (pred_taken && res_taken && (res_btb_entry.target != res_target));

  // Build the update record; a not-taken outcome keeps the old target.
  always_comb begin
    upd              = '0;
    upd.pc           = res_pc;
    upd.entry.target = res_taken ? res_target : res_btb_entry.target;
    upd.entry.ctr    = ctr_next(res_btb_hit, res_taken, res_btb_entry.ctr);
  end

  // Not-taken misses carry no information worth writing. Coalescing into
  // the youngest entry is skipped when that entry is the one leaving now.
  assign enq      = acc && (res_btb_hit || res_taken);
  assign coalesce = enq && !empty && (tail_pc == res_pc) &&
                    !(pop && (fifo_count == (PTR_W+1)'(1)));
  assign push     = enq && !coalesce;

  btb_update_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .push           (push),
    .overwrite_tail (coalesce),
    .wr_data        (upd),
    .pop            (pop),
    .head_data      (head_data),
    .tail_pc        (tail_pc),
    .full           (full),
    .empty          (empty),
    .count          (fifo_count)
  );

  assign btb_write_address = empty ? '0 : head_data.pc;
  assign btb_in            = empty ? '0 : head_data.entry;

  // One-cycle redirect pulse; the redirect PC persists until replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= acc && mis_cond;
      if (acc && mis_cond)
        redirect_pc <= res_taken ? res_target : res_pc + 32'd4;
    end
  end

endmodule
